// File: rtl/alu_seq_if.sv
// Command and response channels between the datapath control logic and alu_seq.
// The master issues commands and consumes responses; the slave is the sequencer.
interface alu_seq_if #(
   parameter int WIDTH  = 8,
   parameter int ITER_W = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_opcode;
   logic [WIDTH-1:0]  cmd_a;
   logic [WIDTH-1:0]  cmd_b;
   logic [ITER_W-1:0] cmd_iter;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_res;
   logic              rsp_zero;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_iter, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_iter, rsp_ready,
      output cmd_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_seq.sv
// Command sequencer for the 8-bit boolean ALU: drives operands/opcode, optionally
// feeds the result back as operand A, and returns the final result with flags.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter int ITER_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_seq_if.slave         bus,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_res
);

   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;

   // ILLEGAL is a one-cycle step so an illegal opcode answers with the same
   // latency as a legal command with no extra iterations.
   typedef enum logic [1:0] {IDLE, EXEC, ILLEGAL, RESP} state_t;

   state_t            state, state_nxt;
   logic [ITER_W-1:0] cnt, cnt_nxt;
   logic [3:0]        op_nxt;
   logic [WIDTH-1:0]  a_nxt, b_nxt, res_nxt;
   logic              valid_nxt, zero_nxt, err_nxt;
   logic              legal;

   assign bus.cmd_ready = (state == IDLE);
   assign legal = (bus.cmd_opcode inside {OP_AND, OP_OR, OP_XOR, OP_NOT});

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_nxt    = alu_opcode;
      a_nxt     = alu_a;
      b_nxt     = alu_b;
      valid_nxt = bus.rsp_valid;
      res_nxt   = bus.rsp_res;
      zero_nxt  = bus.rsp_zero;
      err_nxt   = bus.rsp_err;

      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               cnt_nxt = bus.cmd_iter;
               if (legal) begin
                  op_nxt    = bus.cmd_opcode;
                  a_nxt     = bus.cmd_a;
                  b_nxt     = bus.cmd_b;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = ILLEGAL;
               end
            end
         end
         EXEC: begin
            if (cnt != '0) begin
               a_nxt   = alu_res;
               cnt_nxt = cnt - ITER_W'(1);
            end else begin
               res_nxt   = alu_res;
               zero_nxt  = (alu_res == '0);
               err_nxt   = 1'b0;
               valid_nxt = 1'b1;
               op_nxt    = 4'b0000;
               a_nxt     = '0;
               b_nxt     = '0;
               state_nxt = RESP;
            end
         end
         ILLEGAL: begin
            res_nxt   = '0;
            zero_nxt  = 1'b1;
            err_nxt   = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         alu_opcode    <= 4'b0000;
         alu_a         <= '0;
         alu_b         <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_res   <= '0;
         bus.rsp_zero  <= 1'b0;
         bus.rsp_err   <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         alu_opcode    <= op_nxt;
         alu_a         <= a_nxt;
         alu_b         <= b_nxt;
         bus.rsp_valid <= valid_nxt;
         bus.rsp_res   <= res_nxt;
         bus.rsp_zero  <= zero_nxt;
         bus.rsp_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the boolean ALU
// closing the operand/result loop.
module tb_alu_seq;
   localparam int WIDTH  = 8;
   localparam int ITER_W = 3;

   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_BAD = 4'b0011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

   logic [3:0]       alu_opcode;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;

   alu_seq #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_res    (alu_res)
   );

   always_comb begin
      case (alu_opcode)
         OP_AND:  alu_res = alu_a & alu_b;
         OP_OR:   alu_res = alu_a | alu_b;
         OP_XOR:  alu_res = alu_a ^ alu_b;
         OP_NOT:  alu_res = ~alu_a;
         default: alu_res = '0;
      endcase
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command and returns just after its handshake edge T.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] iter);
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_opcode = op;
      bus.cmd_a      = a;
      bus.cmd_b      = b;
      bus.cmd_iter   = iter;
      bus.cmd_valid  = 1'b1;
      tick();
      bus.cmd_valid  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bus.rsp_ready  = 1'b1;
      bus.cmd_opcode = OP_AND;
      bus.cmd_a      = 8'hFF;
      bus.cmd_b      = 8'hFF;
      bus.cmd_iter   = 3'd0;
      bus.cmd_valid  = 1'b1;

      // Reset: a command offered under reset is not taken.
      #12;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_alu_op",    32'(alu_opcode),    32'd0);
      check("rst_alu_a",     32'(alu_a),         32'd0);
      check("rst_alu_b",     32'(alu_b),         32'd0);
      check("rst_rsp_res",   32'(bus.rsp_res),   32'd0);
      check("rst_rsp_zero",  32'(bus.rsp_zero),  32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // 1: AND F0 & 3C, iter 0.
      send(OP_AND, 8'hF0, 8'h3C, 3'd0);
      check("t1_exec_op",    32'(alu_opcode),    32'(OP_AND));
      check("t1_exec_a",     32'(alu_a),         32'hF0);
      check("t1_exec_b",     32'(alu_b),         32'h3C);
      check("t1_exec_ready", 32'(bus.cmd_ready), 32'd0);
      check("t1_exec_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t1_valid",      32'(bus.rsp_valid), 32'd1);
      check("t1_res",        32'(bus.rsp_res),   32'h30);
      check("t1_zero",       32'(bus.rsp_zero),  32'd0);
      check("t1_err",        32'(bus.rsp_err),   32'd0);
      check("t1_alu_op_clr", 32'(alu_opcode),    32'd0);
      check("t1_resp_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
      check("t1_valid_drop", 32'(bus.rsp_valid), 32'd0);
      check("t1_ready_back", 32'(bus.cmd_ready), 32'd1);
      check("t1_res_hold",   32'(bus.rsp_res),   32'h30);

      // 2: NOT 5A with one and two extra applications.
      send(OP_NOT, 8'h5A, 8'h00, 3'd1);
      check("t2a_a0", 32'(alu_a), 32'h5A);
      tick();
      check("t2a_a1",    32'(alu_a),         32'hA5);
      check("t2a_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t2a_valid2", 32'(bus.rsp_valid), 32'd1);
      check("t2a_res",    32'(bus.rsp_res),   32'h5A);
      tick();
      send(OP_NOT, 8'h5A, 8'h00, 3'd2);
      check("t2b_a0", 32'(alu_a), 32'h5A);
      tick();
      check("t2b_a1", 32'(alu_a), 32'hA5);
      tick();
      check("t2b_a2",    32'(alu_a),         32'h5A);
      check("t2b_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t2b_valid3", 32'(bus.rsp_valid), 32'd1);
      check("t2b_res",    32'(bus.rsp_res),   32'hA5);
      check("t2b_zero",   32'(bus.rsp_zero),  32'd0);
      tick();

      // 3: XOR 00 ^ FF with iter 1 and with the maximum iter 7.
      send(OP_XOR, 8'h00, 8'hFF, 3'd1);
      tick();
      check("t3a_a1", 32'(alu_a), 32'hFF);
      tick();
      check("t3a_valid", 32'(bus.rsp_valid), 32'd1);
      check("t3a_res",   32'(bus.rsp_res),   32'h00);
      check("t3a_zero",  32'(bus.rsp_zero),  32'd1);
      check("t3a_err",   32'(bus.rsp_err),   32'd0);
      tick();
      send(OP_XOR, 8'h00, 8'hFF, 3'd7);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("t3b_a%0d", k),     32'(alu_a),         (k % 2 == 1) ? 32'hFF : 32'h00);
         check($sformatf("t3b_valid%0d", k), 32'(bus.rsp_valid), 32'd0);
      end
      tick();
      check("t3b_valid8", 32'(bus.rsp_valid), 32'd1);
      check("t3b_res",    32'(bus.rsp_res),   32'h00);
      check("t3b_zero",   32'(bus.rsp_zero),  32'd1);
      tick();
      check("t3b_idle", 32'(bus.cmd_ready), 32'd1);
      check("t3b_done", 32'(bus.rsp_valid), 32'd0);

      // 4: illegal opcode.
      send(OP_BAD, 8'h12, 8'h34, 3'd0);
      check("t4_op_t0",  32'(alu_opcode),    32'd0);
      check("t4_a_t0",   32'(alu_a),         32'd0);
      check("t4_valid0", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t4_valid1", 32'(bus.rsp_valid), 32'd1);
      check("t4_res",    32'(bus.rsp_res),   32'h00);
      check("t4_err",    32'(bus.rsp_err),   32'd1);
      check("t4_zero",   32'(bus.rsp_zero),  32'd1);
      check("t4_op_t1",  32'(alu_opcode),    32'd0);
      tick();
      check("t4_valid_drop", 32'(bus.rsp_valid), 32'd0);
      check("t4_err_hold",   32'(bus.rsp_err),   32'd1);

      // 5: OR with backpressure and stray commands during RESP.
      bus.rsp_ready = 1'b0;
      send(OP_OR, 8'h0F, 8'hF0, 3'd0);
      tick();
      bus.cmd_opcode = OP_AND;
      bus.cmd_a      = 8'h00;
      bus.cmd_b      = 8'h00;
      bus.cmd_iter   = 3'd0;
      for (int k = 0; k < 5; k++) begin
         bus.cmd_valid = (k % 2 == 0);
         check($sformatf("t5_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("t5_res%0d", k),   32'(bus.rsp_res),   32'hFF);
         check($sformatf("t5_zero%0d", k),  32'(bus.rsp_zero),  32'd0);
         check($sformatf("t5_err%0d", k),   32'(bus.rsp_err),   32'd0);
         check($sformatf("t5_ready%0d", k), 32'(bus.cmd_ready), 32'd0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      check("t5_no_capture", 32'(alu_opcode),    32'd0);
      check("t5_still_held", 32'(bus.rsp_valid), 32'd1);
      bus.rsp_ready = 1'b1;
      tick();
      check("t5_valid_drop", 32'(bus.rsp_valid), 32'd0);
      check("t5_idle",       32'(bus.cmd_ready), 32'd1);
      tick();
      check("t5_no_second",  32'(bus.rsp_valid), 32'd0);
      check("t5_alu_quiet",  32'(alu_opcode),    32'd0);

      // 6: reset mid-EXEC, then a normal command.
      send(OP_XOR, 8'h00, 8'hFF, 3'd7);
      tick();
      tick();
      check("t6_mid_exec", 32'(alu_a), 32'h00);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_op",    32'(alu_opcode),    32'd0);
      check("t6_rst_a",     32'(alu_a),         32'd0);
      check("t6_rst_b",     32'(alu_b),         32'd0);
      check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("t6_rst_res",   32'(bus.rsp_res),   32'd0);
      check("t6_rst_ready", 32'(bus.cmd_ready), 32'd1);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      send(OP_AND, 8'hAA, 8'hFF, 3'd0);
      check("t6_post_valid0", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t6_post_valid1", 32'(bus.rsp_valid), 32'd1);
      check("t6_post_res",    32'(bus.rsp_res),   32'hAA);
      check("t6_post_zero",   32'(bus.rsp_zero),  32'd0);
      check("t6_post_err",    32'(bus.rsp_err),   32'd0);
      tick();
      check("t6_post_idle", 32'(bus.cmd_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
